fifo_scheduler: RTL

Controller that shares a single 128-bit, 8-entry FIFO between two block producers (source A, source B) and drains it into one downstream consumer.
- Write side: round-robin arbiter with a bounded burst length, driving the FIFO write port.
- Read side: FSM that issues FIFO reads, absorbs the FIFO's one-cycle registered read latency and presents data with a valid/ready handshake.
- Sits between the input block assemblers and the processing core.

---
 rtl/fifo_scheduler.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_scheduler.sv
// Shares one FIFO between two block producers (round-robin, bounded burst) and
// drains it to a single consumer through a valid/ready read FSM.
module fifo_scheduler #(
    parameter int WIDTH     = 128,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reqA,
    input  logic [WIDTH-1:0] dataA,
    output logic             grantA,
    input  logic             reqB,
    input  logic [WIDTH-1:0] dataB,
    output logic             grantB,
    output logic             fifoWrite,
    output logic [WIDTH-1:0] fifoDataIn,
    input  logic             fifoFull,
    output logic             fifoRead,
    input  logic [WIDTH-1:0] fifoDataOut,
    input  logic             fifoEmpty,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    input  logic             outReady,
    output logic             busy
);
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic          prio;        // 0: A preferred, 1: B preferred
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_nxt;
    logic          both;
    logic          cand_a;
    logic          cand_b;
    logic [1:0]    state;

    // ---------------- write-side arbiter ----------------
    always_comb begin
        both       = reqA & reqB;
        cand_a     = reqA & (~reqB | ~prio);
        cand_b     = reqB & (~reqA | prio);
        grantA     = ~rst & cand_a & ~fifoFull;
        grantB     = ~rst & cand_b & ~fifoFull;
        fifoWrite  = grantA | grantB;
        fifoDataIn = grantB ? dataB : dataA;
        burst_nxt  = burst_cnt + 1'b1;
    end

    // Burst counting only matters under contention; a lone requester never
    // consumes the other side's share.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= 1'b0;
            burst_cnt <= '0;
        end else if (grantA | grantB) begin
            if (both) begin
                if (burst_nxt == CW'(MAX_BURST)) begin
                    prio      <= ~prio;
                    burst_cnt <= '0;
                end else begin
                    burst_cnt <= burst_nxt;
                end
            end else begin
                burst_cnt <= '0;
            end
        end
    end

    // ---------------- read-side FSM ----------------
    // FETCH never reads: the empty flag still reflects the pre-read count.
    always_comb begin
        fifoRead = ~rst & ~fifoEmpty &
                   ((state == IDLE) | ((state == HOLD) & outReady));
        outValid = ~rst & (state == HOLD);
        busy     = ~rst & (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            outData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifoEmpty) state <= FETCH;
                end
                FETCH: begin
                    outData <= fifoDataOut;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (outReady) state <= fifoEmpty ? IDLE : FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
